// File: rtl/sprite_scan_blitter.sv
// rtl/sprite_scan_blitter.sv - sprite ROM scanner emitting one plotted pixel per clock
// Coordinates ride a ROM_LAT-deep pipeline so they meet rom_data, then get one output register.
module sprite_scan_blitter #(
    parameter int SPR_W      = 16,
    parameter int SPR_H      = 16,
    parameter int X_W        = 8,
    parameter int Y_W        = 7,
    parameter int COLOR_W    = 3,
    parameter int ROM_LAT    = 1,
    parameter int TRANSP_EN  = 1,
    parameter int TRANSP_COL = 0,
    localparam int ADDR_W    = (SPR_W * SPR_H > 1) ? $clog2(SPR_W * SPR_H) : 1
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic [X_W-1:0]     x_origin,
    input  logic [Y_W-1:0]     y_origin,
    input  logic               mirror,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [COLOR_W-1:0] rom_data,
    output logic [X_W-1:0]     vga_x,
    output logic [Y_W-1:0]     vga_y,
    output logic [COLOR_W-1:0] vga_colour,
    output logic               plot,
    output logic               busy,
    output logic               done
);

    localparam int COL_W = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int ROW_W = (SPR_H > 1) ? $clog2(SPR_H) : 1;
    localparam int DR_W  = $clog2(ROM_LAT + 1) + 1;

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    state_t             state;
    logic [COL_W-1:0]   pc [0:ROM_LAT];
    logic [ROW_W-1:0]   pr [0:ROM_LAT];
    logic               pv [0:ROM_LAT];
    logic [X_W-1:0]     x_org;
    logic [Y_W-1:0]     y_org;
    logic               mir;
    logic [DR_W-1:0]    dcnt;

    logic               last_col;
    logic               last_row;
    logic               is_transp;
    logic [COL_W-1:0]   xoff;

    // Stage 0 holds the col/row of the address currently on rom_addr.
    assign last_col  = (pc[0] == COL_W'(SPR_W - 1));
    assign last_row  = (pr[0] == ROW_W'(SPR_H - 1));
    assign is_transp = (TRANSP_EN != 0) && (rom_data == COLOR_W'(TRANSP_COL));
    assign xoff      = mir ? (COL_W'(SPR_W - 1) - pc[ROM_LAT]) : pc[ROM_LAT];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            rom_addr   <= '0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            plot       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            x_org      <= '0;
            y_org      <= '0;
            mir        <= 1'b0;
            dcnt       <= '0;
            for (int i = 0; i <= ROM_LAT; i++) begin
                pc[i] <= '0;
                pr[i] <= '0;
                pv[i] <= 1'b0;
            end
        end else begin
            done <= 1'b0;
            for (int i = 1; i <= ROM_LAT; i++) begin
                pc[i] <= pc[i-1];
                pr[i] <= pr[i-1];
                pv[i] <= pv[i-1];
            end
            plot       <= pv[ROM_LAT] && !is_transp;
            vga_x      <= x_org + X_W'(xoff);
            vga_y      <= y_org + Y_W'(pr[ROM_LAT]);
            vga_colour <= rom_data;

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= SCAN;
                        busy     <= 1'b1;
                        x_org    <= x_origin;
                        y_org    <= y_origin;
                        mir      <= mirror;
                        rom_addr <= '0;
                        pc[0]    <= '0;
                        pr[0]    <= '0;
                        pv[0]    <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        pv[0] <= 1'b0;
                    end
                end
                SCAN: begin
                    if (last_col && last_row) begin
                        state <= DRAIN;
                        pv[0] <= 1'b0;
                        dcnt  <= '0;
                    end else begin
                        rom_addr <= rom_addr + ADDR_W'(1);
                        if (last_col) begin
                            pc[0] <= '0;
                            pr[0] <= pr[0] + ROW_W'(1);
                        end else begin
                            pc[0] <= pc[0] + COL_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    // Wait for the last address to cross the ROM and the output register.
                    if (dcnt == DR_W'(ROM_LAT)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        dcnt <= dcnt + DR_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_scan_blitter.sv
// tb/tb_sprite_scan_blitter.sv - bench for sprite_scan_blitter over five parameter sets
`timescale 1ns/1ps
module tb_sprite_scan_blitter;

    function automatic int cfg_w(int g);   return (g == 3) ? 4 : 16; endfunction
    function automatic int cfg_h(int g);   return (g == 3) ? 2 : 16; endfunction
    function automatic int cfg_lat(int g); return (g < 3) ? g + 1 : 1; endfunction
    function automatic logic [2:0] rom_fn(int g, logic [7:0] a);
        if (g == 4) return a[0] ? a[2:0] : 3'd0;
        return a[2:0];
    endfunction

    logic       clk = 1'b0;
    logic       resetn;
    logic       start_v [5];
    logic [7:0] ox;
    logic [6:0] oy;
    logic       mir;
    logic [7:0] ra [5];
    logic [7:0] vx [5];
    logic [6:0] vy [5];
    logic [2:0] vc [5];
    logic       pl [5];
    logic       bs [5];
    logic       dn [5];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 5; g++) begin : gi
        localparam int SW  = cfg_w(g);
        localparam int SH  = cfg_h(g);
        localparam int LAT = cfg_lat(g);
        localparam int TEN = (g == 4) ? 1 : 0;
        localparam int AW  = $clog2(SW * SH);
        logic [AW-1:0] a;
        logic [2:0]    rd [LAT];

        sprite_scan_blitter #(
            .SPR_W(SW), .SPR_H(SH), .X_W(8), .Y_W(7), .COLOR_W(3),
            .ROM_LAT(LAT), .TRANSP_EN(TEN), .TRANSP_COL(0)
        ) dut (
            .clk(clk), .resetn(resetn), .start(start_v[g]),
            .x_origin(ox), .y_origin(oy), .mirror(mir),
            .rom_addr(a), .rom_data(rd[LAT-1]),
            .vga_x(vx[g]), .vga_y(vy[g]), .vga_colour(vc[g]),
            .plot(pl[g]), .busy(bs[g]), .done(dn[g])
        );

        assign ra[g] = 8'(a);

        always_ff @(posedge clk) begin
            rd[0] <= rom_fn(g, 8'(a));
            for (int i = 1; i < LAT; i++) rd[i] <= rd[i-1];
        end
    end

    typedef struct {
        int g; int ox; int oy; int mir;
        int fx; int fy; int lx; int ly; int plots; int done_c;
    } vec_t;

    typedef struct { int x; int y; int c; int cyc; } pix_t;

    vec_t tab [6];
    pix_t q [$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic run_blit(input vec_t v, input bit pulses, input bit chain_in, input bit chain_out);
        int n, lat, plots, done_n, done_c, busy_bad, fx, fy, lx, ly;
        pix_t p;
        n   = cfg_w(v.g) * cfg_h(v.g);
        lat = cfg_lat(v.g);
        plots = 0; done_n = 0; done_c = -1; busy_bad = 0;
        fx = -1; fy = -1; lx = -1; ly = -1;
        q.delete();
        for (int k = 0; k < n; k++) begin
            int col, row, c;
            col = k % cfg_w(v.g);
            row = k / cfg_w(v.g);
            c   = int'(rom_fn(v.g, 8'(k)));
            p.x   = (v.ox + (v.mir != 0 ? cfg_w(v.g) - 1 - col : col)) % 256;
            p.y   = (v.oy + row) % 128;
            p.c   = c;
            p.cyc = k + lat + 1;
            if (!(v.g == 4 && c == 0)) q.push_back(p);
        end
        ox  = 8'(v.ox);
        oy  = 7'(v.oy);
        mir = v.mir[0];
        if (!chain_in) begin
            @(negedge clk);
            start_v[v.g] = 1'b1;
        end
        @(posedge clk);
        #1;
        start_v[v.g] = 1'b0;
        ox = 8'hA5; oy = 7'h55; mir = ~mir;
        if (chain_in) begin
            chk("chain_cycle0_addr", int'(ra[v.g]), 0);
            chk("chain_cycle0_busy", int'(bs[v.g]), 1);
        end
        for (int c = 0; c < n + lat + 8; c++) begin
            if (bs[v.g] != (c <= n + lat)) busy_bad++;
            if (dn[v.g]) begin done_n++; done_c = c; end
            if (pl[v.g]) begin
                plots++;
                if (fx < 0) begin fx = int'(vx[v.g]); fy = int'(vy[v.g]); end
                lx = int'(vx[v.g]); ly = int'(vy[v.g]);
                if (q.size() == 0) begin
                    chk("extra_plot_cycle", c, -1);
                end else begin
                    p = q.pop_front();
                    checks++;
                    if (int'(vx[v.g]) != p.x || int'(vy[v.g]) != p.y ||
                        int'(vc[v.g]) != p.c || c != p.cyc) begin
                        failures++;
                        $display("FAIL pixel cfg%0d actual x=%0d y=%0d col=%0d cyc=%0d required x=%0d y=%0d col=%0d cyc=%0d",
                                 v.g, vx[v.g], vy[v.g], vc[v.g], c, p.x, p.y, p.c, p.cyc);
                    end
                end
            end
            if (pulses) start_v[v.g] = (c == 5 || c == 100);
            if (chain_out && c == v.done_c) begin
                start_v[v.g] = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("done_cycle", done_c, v.done_c);
        chk("done_count", done_n, 1);
        chk("plot_count", plots, v.plots);
        chk("busy_window_errors", busy_bad, 0);
        chk("first_x", fx, v.fx);
        chk("first_y", fy, v.fy);
        chk("last_x", lx, v.lx);
        chk("last_y", ly, v.ly);
        chk("scoreboard_left", q.size(), 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_addr"},   int'(ra[0]), 0);
        chk({tag, "_x"},      int'(vx[0]), 0);
        chk({tag, "_y"},      int'(vy[0]), 0);
        chk({tag, "_colour"}, int'(vc[0]), 0);
        chk({tag, "_plot"},   int'(pl[0]), 0);
        chk({tag, "_busy"},   int'(bs[0]), 0);
        chk({tag, "_done"},   int'(dn[0]), 0);
    endtask

    initial begin
        int pc_n, dc_n, bc_n;
        tab[0] = '{0,  10,  20, 0,  10,  20, 25, 35, 256, 258};
        tab[1] = '{1,  10,  20, 0,  10,  20, 25, 35, 256, 259};
        tab[2] = '{2,  10,  20, 0,  10,  20, 25, 35, 256, 260};
        tab[3] = '{3,   0,   0, 1,   3,   0,  0,  1,   8,  10};
        tab[4] = '{4,  10,  20, 0,  11,  20, 25, 35, 128, 258};
        tab[5] = '{0, 250, 125, 0, 250, 125,  9, 12, 256, 258};

        resetn = 1'b0;
        for (int i = 0; i < 5; i++) start_v[i] = 1'b0;
        ox = '0; oy = '0; mir = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 6; i++) run_blit(tab[i], 1'b0, 1'b0, 1'b0);

        // Ignored starts mid-blit, then a start in the done cycle chains a second blit.
        run_blit(tab[0], 1'b1, 1'b0, 1'b1);
        run_blit(tab[5], 1'b0, 1'b1, 1'b0);

        // Reset at cycle 50 aborts the blit.
        ox = 8'd10; oy = 7'd20; mir = 1'b0;
        @(negedge clk);
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        chk("pre_reset_plot", int'(pl[0]), 1);
        chk("pre_reset_busy", int'(bs[0]), 1);
        resetn = 1'b0;
        #1;
        chk_zero("async");
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        pc_n = 0; dc_n = 0; bc_n = 0;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk);
            #1;
            if (pl[0]) pc_n++;
            if (dn[0]) dc_n++;
            if (bs[0]) bc_n++;
        end
        chk("post_abort_plots", pc_n, 0);
        chk("post_abort_done", dc_n, 0);
        chk("post_abort_busy", bc_n, 0);
        run_blit(tab[0], 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=expired required=finished");
        $fatal(1, "timeout");
    end

endmodule
